// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 raster scan controller on the pixel clock.
// Generates the h/v counters, sync and blanking, issues one FIFO read per
// active pixel, and registers the returned pixel onto the DAC outputs with
// sync/blank delayed by the same two cycles so everything stays aligned.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] pixel_r,
  input  logic [7:0] pixel_g,
  input  logic [7:0] pixel_b,
  output logic       rd_fifo,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = !SYNC_ON;

  // Map an internal "sync asserted" flag onto the configured pin polarity.
  function automatic logic sync_level(input logic asserted);
    return asserted ? SYNC_ON : SYNC_OFF;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       end_of_frame;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       vld_p1;
  logic       hs_p1;
  logic       vs_p1;

  assign end_of_frame = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // State register.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start on en, stop only at a frame boundary so frames are never cut short.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (end_of_frame && !en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered counters and state.
  always_comb begin
    active      = 1'b0;
    hsync_raw   = 1'b0;
    vsync_raw   = 1'b0;
    frame_start = 1'b0;
    if (state == RUN) begin
      active      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hsync_raw   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vsync_raw   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
    rd_fifo = active;
    pixel_x = h_cnt;
    pixel_y = v_cnt;
  end

  // Raster counters: advance every RUN cycle, held at the origin while idle.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (state == RUN) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 10'd0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end else begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end
  end

  // ---- stage p1: delay active/sync by one cycle to meet the FIFO read data ----
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      vld_p1 <= active;
      hs_p1  <= hsync_raw;
      vs_p1  <= vsync_raw;
    end
  end

  // ---- stage p2: register pixel and delayed timing onto the DAC outputs together ----
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      vga_r     <= 8'd0;
      vga_g     <= 8'd0;
      vga_b     <= 8'd0;
      vga_hsync <= SYNC_OFF;
      vga_vsync <= SYNC_OFF;
      vga_blank <= 1'b1;
    end else begin
      vga_r     <= vld_p1 ? pixel_r : 8'd0;
      vga_g     <= vld_p1 ? pixel_g : 8'd0;
      vga_b     <= vld_p1 ? pixel_b : 8'd0;
      vga_hsync <= sync_level(hs_p1);
      vga_vsync <= sync_level(vs_p1);
      vga_blank <= !vld_p1;
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

VGA 640x480@60 Hz scan controller on the pixel clock domain. It sits directly downstream of `main_logic`. It generates the counters, sync and blanking for the display. It drives `rd_fifo` to pull one 24-bit pixel per active pixel clock from the cross-clock FIFO, and it registers the returned `pixel_r/g/b` onto the DAC outputs, aligned with the delayed sync signals.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (frame total 525)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active low)

Ports:
- clk_25mhz  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  start/keep scanning
- pixel_r / pixel_g / pixel_b  in  8 each  FIFO pixel data; valid one cycle after `rd_fifo`
- rd_fifo  out  1  FIFO read request, one per active pixel
- vga_hsync / vga_vsync  out  1 each  sync outputs, pipeline-aligned to RGB
- vga_blank  out  1  1 = outside active video, pipeline-aligned
- vga_r / vga_g / vga_b  out  8 each  registered pixel outputs, 0 while blanked
- pixel_x / pixel_y  out  10 each  current counter position (undelayed)
- frame_start  out  1  one-cycle pulse at h=0, v=0 of every frame in RUN

## Operation
- FSM states:
  - IDLE: counters held at 0; rd_fifo=0; syncs at inactive level; blank=1.
  - IDLE->RUN: on the first edge with en=1.
  - RUN->IDLE: only at end of frame (h=799, v=524) when en=0. Frames are never truncated by en.
- h_cnt 0..799 increments every RUN cycle and wraps to 0. At the wrap, v_cnt increments 0..524 and then wraps to 0.
- Active region: h_cnt<640 and v_cnt<480, in RUN.
- rd_fifo: combinational decode of the registered counters and state; equals active. It is never asserted in IDLE or during blanking. The block asserts exactly 640 reads per active line and 307200 per frame.
- Raw hsync asserted for h_cnt 656..751. Raw vsync asserted for v_cnt 490..491 (all h). Both are driven at SYNC_POL.
- Stage 1 registers active, raw hsync, raw vsync.
- Stage 2 updates every output register at the same edge:
  - vga_r/g/b <= stage1 active ? pixel_r/g/b : 0
  - vga_hsync, vga_vsync, vga_blank from stage 1 (blank = ~active)
- frame_start: combinational, (state==RUN && h_cnt==0 && v_cnt==0).
- Counter arithmetic is 10-bit unsigned. Comparisons are derived from the parameters and are not hard-coded.

## Timing
- Reset values:
  - h_cnt=v_cnt=0, state IDLE
  - rd_fifo=0, frame_start=0
  - vga_hsync=vga_vsync=~SYNC_POL (1)
  - vga_blank=1, vga_r/g/b=0
  - pixel_x=pixel_y=0
  - both pipeline stages cleared to the inactive level
- Reset is asynchronous: all of the above take effect immediately on rst rising, including mid-line and mid-frame. After rst falls, scanning restarts from IDLE.
- Latency:
  - Counter value at cycle t drives rd_fifo at t.
  - FIFO dout is valid at t+1.
  - vga_* for that pixel are visible at t+2.
  - hsync, vsync and blank carry the same 2-cycle delay, so RGB and syncs stay aligned.
- en rising in IDLE: RUN with h=0, v=0 in the next cycle. frame_start and the first rd_fifo occur in that cycle.
- Line period is 800 cycles. Frame period is 420000 cycles. Back-to-back frames have no gap while en=1.
- Simultaneous en=0 and end of frame: transition to IDLE on that edge, with counters at 0.

## Test plan
- Reset mid-operation: assert rst at h=300, v=100 -> all outputs show reset values within the same cycle. Release rst with en=1 -> frame_start occurs 1 cycle after the first en-sampled edge.
- Read count: run 2 frames with en=1 -> exactly 640 rd_fifo cycles per line and 307200 per frame. rd_fifo=0 for h in 640..799 and v in 480..524.
- Horizontal sync: vga_hsync is 0 for exactly 96 cycles with an 800-cycle period. Its falling edge occurs 2 cycles after h_cnt=656.
- Vertical sync: vga_vsync is 0 for exactly 1600 cycles per frame. Its falling edge occurs 2 cycles after (h=0, v=490). The frame period is 420000 cycles.
- Data alignment: a FIFO model returns incrementing 24-bit values one cycle after each read -> vga_{r,g,b} shows 0x000000 while blank=1. The first visible pixel of a line equals the value returned for the first read of that line, and the order is preserved with no drops or repeats.
- en drop mid-frame: deassert en at v=200 -> scanning continues through (h=799, v=524), then enters IDLE. rd_fifo totals 307200 for that frame, and no frame_start pulse follows.
